// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - In-order writeback FIFO feeding the register file write port
// with youngest-match forwarding to the two decode read ports.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_in_valid,
  output logic                      io_in_ready,
  input  logic [4:0]                io_in_waddr,
  input  logic [XLEN-1:0]           io_in_wdata,
  input  logic                      io_drain_en,
  output logic                      io_rf_wen,
  output logic [4:0]                io_rf_waddr,
  output logic [XLEN-1:0]           io_rf_wdata,
  input  logic [4:0]                io_raddr1,
  input  logic [4:0]                io_raddr2,
  output logic                      io_fwd_hit1,
  output logic [XLEN-1:0]           io_fwd_data1,
  output logic                      io_fwd_hit2,
  output logic [XLEN-1:0]           io_fwd_data2,
  output logic [$clog2(DEPTH):0]    io_count,
  output logic                      io_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic [4:0]      waddr_q [DEPTH];
  logic [4:0]      waddr_d [DEPTH];
  logic [XLEN-1:0] wdata_q [DEPTH];
  logic [XLEN-1:0] wdata_d [DEPTH];
  logic            push, pop;
  logic [PW-1:0]   idx;

  // Ready is gated by reset so nothing is accepted while the queue is held clear.
  assign io_in_ready  = reset & (count_q != FULL);
  assign io_rf_wen    = reset & (count_q != '0) & io_drain_en;
  assign io_rf_waddr  = io_rf_wen ? waddr_q[head_q] : '0;
  assign io_rf_wdata  = io_rf_wen ? wdata_q[head_q] : '0;
  assign io_count     = count_q;
  assign io_busy      = (count_q != '0);

  // x0 writes complete the handshake but are never stored.
  assign push = io_in_valid & io_in_ready & (io_in_waddr != 5'd0);
  assign pop  = io_rf_wen;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (push) begin
      waddr_d[tail_q] = io_in_waddr;
      wdata_d[tail_q] = io_in_wdata;
      tail_d          = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);
  end

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    io_fwd_hit1  = 1'b0;
    io_fwd_data1 = '0;
    io_fwd_hit2  = 1'b0;
    io_fwd_data2 = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((PW+1)'(i) < count_q) begin
        if (io_raddr1 != 5'd0 && waddr_q[idx] == io_raddr1) begin
          io_fwd_hit1  = 1'b1;
          io_fwd_data1 = wdata_q[idx];
        end
        if (io_raddr2 != 5'd0 && waddr_q[idx] == io_raddr2) begin
          io_fwd_hit2  = 1'b1;
          io_fwd_data2 = wdata_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    push |-> (count_q != FULL));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
    pop |-> (count_q != '0));

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - Self-checking bench: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            io_in_valid = 1'b0;
  logic            io_in_ready;
  logic [4:0]      io_in_waddr = '0;
  logic [XLEN-1:0] io_in_wdata = '0;
  logic            io_drain_en = 1'b0;
  logic            io_rf_wen;
  logic [4:0]      io_rf_waddr;
  logic [XLEN-1:0] io_rf_wdata;
  logic [4:0]      io_raddr1 = '0;
  logic [4:0]      io_raddr2 = '0;
  logic            io_fwd_hit1;
  logic [XLEN-1:0] io_fwd_data1;
  logic            io_fwd_hit2;
  logic [XLEN-1:0] io_fwd_data2;
  logic [2:0]      io_count;
  logic            io_busy;

  regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_waddr(io_in_waddr), .io_in_wdata(io_in_wdata),
    .io_drain_en(io_drain_en), .io_rf_wen(io_rf_wen),
    .io_rf_waddr(io_rf_waddr), .io_rf_wdata(io_rf_wdata),
    .io_raddr1(io_raddr1), .io_raddr2(io_raddr2),
    .io_fwd_hit1(io_fwd_hit1), .io_fwd_data1(io_fwd_data1),
    .io_fwd_hit2(io_fwd_hit2), .io_fwd_data2(io_fwd_data2),
    .io_count(io_count), .io_busy(io_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        valid;
    logic [4:0]  a;
    logic [31:0] d;
    logic        drain;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ready;
    logic        e_wen;
    logic [4:0]  e_rfa;
    logic [31:0] e_rfd;
    logic        e_h1;
    logic [31:0] e_f1;
    logic        e_h2;
    logic [31:0] e_f2;
    int          e_cnt;
  } vec_t;

  ent_t mq[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    int          n;
    logic        h1, h2, wen;
    logic [31:0] f1, f2;
    n  = mq.size();
    h1 = 1'b0; f1 = '0; h2 = 1'b0; f2 = '0;
    for (int i = 0; i < n; i++) begin
      if (io_raddr1 != 0 && mq[i].a == io_raddr1) begin h1 = 1'b1; f1 = mq[i].d; end
      if (io_raddr2 != 0 && mq[i].a == io_raddr2) begin h2 = 1'b1; f2 = mq[i].d; end
    end
    wen = (n > 0) && io_drain_en;
    chk("ready", io_in_ready, n < DEPTH);
    chk("rf_wen", io_rf_wen, wen);
    chk("rf_waddr", io_rf_waddr, wen ? mq[0].a : 5'd0);
    chk("rf_wdata", io_rf_wdata, wen ? mq[0].d : 32'd0);
    chk("hit1", io_fwd_hit1, h1);
    chk("fwd1", io_fwd_data1, f1);
    chk("hit2", io_fwd_hit2, h2);
    chk("fwd2", io_fwd_data2, f2);
    chk("count", io_count, n);
    chk("busy", io_busy, n != 0);
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = mq.size() < DEPTH;
    if (io_drain_en && mq.size() > 0) void'(mq.pop_front());
    if (io_in_valid && rdy && io_in_waddr != 0) mq.push_back('{io_in_waddr, io_in_wdata});
  endtask

  // Inputs are set 1ns after a rising edge; outputs are checked mid-cycle.
  task automatic cycle(input bit use_model);
    #4;
    if (use_model) check_model();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic dr, input logic [4:0] r1, input logic [4:0] r2);
    io_in_valid = v; io_in_waddr = a; io_in_wdata = d;
    io_drain_en = dr; io_raddr1 = r1; io_raddr2 = r2;
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [31:0] d,
      input logic dr, input logic [4:0] r1, input logic [4:0] r2,
      input logic er, input logic ew, input logic [4:0] ea, input logic [31:0] ed,
      input logic eh1, input logic [31:0] ef1, input logic eh2, input logic [31:0] ef2,
      input int ec);
    vec_t t;
    t = '{v, a, d, dr, r1, r2, er, ew, ea, ed, eh1, ef1, eh2, ef2, ec};
    return t;
  endfunction

  initial begin
    // single enqueue/drain, fill-then-drain with duplicate x1, x0 drop
    tbl.push_back(mk(1, 5, 32'h11111111, 1, 5, 0,  1, 0, 0, 0,             0, 0,   0, 0,   0));
    tbl.push_back(mk(0, 0, 0,            1, 5, 0,  1, 1, 5, 32'h11111111,  1, 32'h11111111, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0,            0, 5, 0,  1, 0, 0, 0,             0, 0,   0, 0,   0));
    tbl.push_back(mk(1, 1, 32'hA,        0, 1, 0,  1, 0, 0, 0,             0, 0,   0, 0,   0));
    tbl.push_back(mk(1, 2, 32'hB,        0, 1, 0,  1, 0, 0, 0,             1, 32'hA, 0, 0, 1));
    tbl.push_back(mk(1, 1, 32'hC,        0, 1, 0,  1, 0, 0, 0,             1, 32'hA, 0, 0, 2));
    tbl.push_back(mk(1, 3, 32'hD,        0, 1, 3,  1, 0, 0, 0,             1, 32'hC, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0,            0, 1, 3,  0, 0, 0, 0,             1, 32'hC, 1, 32'hD, 4));
    tbl.push_back(mk(0, 0, 0,            1, 1, 3,  0, 1, 1, 32'hA,         1, 32'hC, 1, 32'hD, 4));
    tbl.push_back(mk(0, 0, 0,            1, 1, 3,  1, 1, 2, 32'hB,         1, 32'hC, 1, 32'hD, 3));
    tbl.push_back(mk(0, 0, 0,            1, 1, 3,  1, 1, 1, 32'hC,         1, 32'hC, 1, 32'hD, 2));
    tbl.push_back(mk(0, 0, 0,            1, 1, 3,  1, 1, 3, 32'hD,         0, 0,   1, 32'hD, 1));
    tbl.push_back(mk(0, 0, 0,            1, 1, 3,  1, 0, 0, 0,             0, 0,   0, 0,   0));
    tbl.push_back(mk(1, 0, 32'hDEADBEEF, 1, 0, 0,  1, 0, 0, 0,             0, 0,   0, 0,   0));
    tbl.push_back(mk(0, 0, 0,            1, 0, 0,  1, 0, 0, 0,             0, 0,   0, 0,   0));

    // reset held low with a pending request
    drive(1, 5, 32'h1234, 1, 5, 5);
    @(posedge clock); #5;
    chk("rst_ready", io_in_ready, 1'b0);
    chk("rst_wen", io_rf_wen, 1'b0);
    chk("rst_count", io_count, 3'd0);
    chk("rst_busy", io_busy, 1'b0);
    reset = 1'b1;
    #1;
    chk("rel_ready", io_in_ready, 1'b1);
    chk("rel_count", io_count, 3'd0);
    chk("rel_busy", io_busy, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;

    foreach (tbl[k]) begin
      drive(tbl[k].valid, tbl[k].a, tbl[k].d, tbl[k].drain, tbl[k].r1, tbl[k].r2);
      #4;
      chk($sformatf("t%0d_ready", k), io_in_ready, tbl[k].e_ready);
      chk($sformatf("t%0d_wen", k), io_rf_wen, tbl[k].e_wen);
      chk($sformatf("t%0d_rfa", k), io_rf_waddr, tbl[k].e_rfa);
      chk($sformatf("t%0d_rfd", k), io_rf_wdata, tbl[k].e_rfd);
      chk($sformatf("t%0d_h1", k), io_fwd_hit1, tbl[k].e_h1);
      chk($sformatf("t%0d_f1", k), io_fwd_data1, tbl[k].e_f1);
      chk($sformatf("t%0d_h2", k), io_fwd_hit2, tbl[k].e_h2);
      chk($sformatf("t%0d_f2", k), io_fwd_data2, tbl[k].e_f2);
      chk($sformatf("t%0d_cnt", k), io_count, tbl[k].e_cnt);
      chk($sformatf("t%0d_busy", k), io_busy, tbl[k].e_cnt != 0);
      model_edge();
      @(posedge clock); #1;
    end

    // steady state at count=2 with pointers wrapping several times
    drive(1, 7, 32'h70, 0, 7, 8); cycle(1);
    drive(1, 8, 32'h80, 0, 7, 8); cycle(1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'(9 + i), 32'h100 + i, 1, 5'(9 + i), 5'(8 + i));
      #4;
      chk("steady_count", io_count, 3'd2);
      chk("steady_wen", io_rf_wen, 1'b1);
      #(-4 + 4);
      check_model();
      model_edge();
      @(posedge clock); #1;
    end
    drive(0, 0, 0, 1, 0, 0); cycle(1); cycle(1); cycle(1);

    // asynchronous reset mid-cycle with three pending writes
    drive(1, 4, 32'h44, 0, 4, 6); cycle(1);
    drive(1, 6, 32'h66, 0, 4, 6); cycle(1);
    drive(1, 4, 32'h45, 0, 4, 6); cycle(1);
    drive(1, 9, 32'h99, 1, 4, 6);
    #4;
    check_model();
    #1;
    reset = 1'b0;
    #1;
    mq.delete();
    chk("arst_ready", io_in_ready, 1'b0);
    chk("arst_wen", io_rf_wen, 1'b0);
    chk("arst_rfa", io_rf_waddr, 5'd0);
    chk("arst_hit1", io_fwd_hit1, 1'b0);
    chk("arst_fwd1", io_fwd_data1, 32'd0);
    chk("arst_hit2", io_fwd_hit2, 1'b0);
    chk("arst_count", io_count, 3'd0);
    chk("arst_busy", io_busy, 1'b0);
    @(posedge clock); #5;
    reset = 1'b1;
    drive(0, 0, 0, 1, 4, 6);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) cycle(1);

    // randomized traffic with frequent register collisions
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
